// File: rtl/day_one_pkg.sv
// Shared constants and types for the day-one calibration line encoder.
package day_one_pkg;

    localparam logic [7:0] CHAR_FILL = 8'h71;  // 'q': appears in no digit word
    localparam logic [7:0] CHAR_NL   = 8'h0A;  // line terminator
    localparam logic [7:0] CHAR_ZERO = 8'h30;  // '0', base for ASCII digits

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_FIRST,
        ST_MID,
        ST_LAST,
        ST_EOL
    } enc_state_t;

    // Length of the spelled-out word for digits one..nine
    localparam logic [2:0] WORD_LEN [1:9] = '{3'd3, 3'd3, 3'd5, 3'd4, 3'd4,
                                              3'd3, 3'd5, 3'd5, 3'd4};

    // Digits outside 0..9 are transmitted as zero
    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        return (d > 4'd9) ? 4'd0 : d;
    endfunction

endpackage

// File: rtl/digit_word_rom.sv
// Character lookup for spelled digit words; index past the word end reads 8'h00.
module digit_word_rom
    import day_one_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] idx,
    output logic [7:0] chr,
    output logic [2:0] len
);

    logic [39:0] word;

    // Select the left-aligned word text and its length, then pick one character
    always_comb begin
        word = 40'h0;
        len  = 3'd0;
        chr  = 8'h00;
        case (digit)
            4'd1: begin word = {"one",   16'h0}; len = WORD_LEN[1]; end
            4'd2: begin word = {"two",   16'h0}; len = WORD_LEN[2]; end
            4'd3: begin word = "three";          len = WORD_LEN[3]; end
            4'd4: begin word = {"four",   8'h0}; len = WORD_LEN[4]; end
            4'd5: begin word = {"five",   8'h0}; len = WORD_LEN[5]; end
            4'd6: begin word = {"six",   16'h0}; len = WORD_LEN[6]; end
            4'd7: begin word = "seven";          len = WORD_LEN[7]; end
            4'd8: begin word = "eight";          len = WORD_LEN[8]; end
            4'd9: begin word = {"nine",   8'h0}; len = WORD_LEN[9]; end
            default: begin word = 40'h0; len = 3'd0; end
        endcase
        if (idx < len) begin
            case (idx)
                3'd0:    chr = word[39:32];
                3'd1:    chr = word[31:24];
                3'd2:    chr = word[23:16];
                3'd3:    chr = word[15:8];
                3'd4:    chr = word[7:0];
                default: chr = 8'h00;
            endcase
        end
    end

endmodule

// File: rtl/calib_line_encoder.sv
// Emits one calibration line per accepted (first, last) request:
// PRE_LEN fillers, first digit, MID_LEN fillers, last digit, newline.
module calib_line_encoder
    import day_one_pkg::*;
#(
    parameter int PRE_LEN = 2,
    parameter int MID_LEN = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [3:0] req_first,
    input  logic [3:0] req_last,
    input  logic       req_spell,
    output logic [7:0] char_out,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       line_done,
    output logic       bad_req
);

    // A zero-length phase is never entered, so the wrapped value is never compared
    localparam logic [3:0] PRE_END = 4'(PRE_LEN - 1);
    localparam logic [3:0] MID_END = 4'(MID_LEN - 1);

    enc_state_t state, ns;
    logic [3:0] fill_cnt, nfill;
    logic [2:0] word_idx, nidx;
    logic [2:0] cur_len, nlen;
    logic [3:0] first_q, last_q;
    logic       spell_q;
    logic       accept, xfer;
    logic [3:0] op_first, nd;
    logic       op_spell, spelled;
    logic [7:0] rom_chr, nchar;
    logic [2:0] rom_len;

    assign req_ready = (state == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign xfer      = char_valid && char_ready;

    // While idle the incoming request is the operand source so the first char is ready next cycle
    assign op_first  = (state == ST_IDLE) ? clamp_digit(req_first) : first_q;
    assign op_spell  = (state == ST_IDLE) ? req_spell : spell_q;

    // Phase sequencing; counters restart on entry and only advance on a transfer
    always_comb begin
        ns    = state;
        nfill = fill_cnt;
        nidx  = word_idx;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    ns    = (PRE_LEN != 0) ? ST_PRE : ST_FIRST;
                    nfill = 4'd0;
                    nidx  = 3'd0;
                end
            end
            ST_PRE: begin
                if (xfer) begin
                    if (fill_cnt == PRE_END) begin
                        ns    = ST_FIRST;
                        nfill = 4'd0;
                        nidx  = 3'd0;
                    end else begin
                        nfill = fill_cnt + 4'd1;
                    end
                end
            end
            ST_FIRST: begin
                if (xfer) begin
                    if (word_idx == cur_len - 3'd1) begin
                        ns    = (MID_LEN != 0) ? ST_MID : ST_LAST;
                        nfill = 4'd0;
                        nidx  = 3'd0;
                    end else begin
                        nidx = word_idx + 3'd1;
                    end
                end
            end
            ST_MID: begin
                if (xfer) begin
                    if (fill_cnt == MID_END) begin
                        ns    = ST_LAST;
                        nfill = 4'd0;
                        nidx  = 3'd0;
                    end else begin
                        nfill = fill_cnt + 4'd1;
                    end
                end
            end
            ST_LAST: begin
                if (xfer) begin
                    if (word_idx == cur_len - 3'd1) begin
                        ns   = ST_EOL;
                        nidx = 3'd0;
                    end else begin
                        nidx = word_idx + 3'd1;
                    end
                end
            end
            ST_EOL: begin
                if (xfer) ns = ST_IDLE;
            end
            default: ns = ST_IDLE;
        endcase
    end

    // Character for the upcoming beat, derived from the next state and counters
    always_comb begin
        nd      = (ns == ST_LAST) ? last_q : op_first;
        spelled = op_spell && (nd != 4'd0);
        nlen    = spelled ? rom_len : 3'd1;
        case (ns)
            ST_PRE, ST_MID:    nchar = CHAR_FILL;
            ST_FIRST, ST_LAST: nchar = spelled ? rom_chr : (CHAR_ZERO + {4'd0, nd});
            ST_EOL:            nchar = CHAR_NL;
            default:           nchar = 8'h00;
        endcase
    end

    digit_word_rom u_rom (
        .digit (nd),
        .idx   (nidx),
        .chr   (rom_chr),
        .len   (rom_len)
    );

    // Control and output registers; reset aborts any line in progress
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            fill_cnt   <= 4'd0;
            word_idx   <= 3'd0;
            cur_len    <= 3'd1;
            char_out   <= 8'h00;
            char_valid <= 1'b0;
            line_done  <= 1'b0;
            bad_req    <= 1'b0;
        end else begin
            state      <= ns;
            fill_cnt   <= nfill;
            word_idx   <= nidx;
            cur_len    <= nlen;
            char_out   <= nchar;
            char_valid <= (ns != ST_IDLE);
            line_done  <= (state == ST_EOL) && xfer;
            if (accept && ((req_first > 4'd9) || (req_last > 4'd9)))
                bad_req <= 1'b1;
        end
    end

    // Operand capture at request acceptance
    always_ff @(posedge clk) begin
        if (accept) begin
            first_q <= clamp_digit(req_first);
            last_q  <= clamp_digit(req_last);
            spell_q <= req_spell;
        end
    end

endmodule

// File: tb/tb_calib_line_encoder.sv
// Bench for calib_line_encoder: default-length and zero-length instances,
// scoreboard of expected characters, decoder model for loopback lines.
module tb_calib_line_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid_a, req_valid_b;
    logic [3:0] req_first, req_last;
    logic       req_spell;
    logic       char_ready;

    logic       rr_a, cv_a, ld_a, bad_a;
    logic [7:0] co_a;
    logic       rr_b, cv_b, ld_b, bad_b;
    logic [7:0] co_b;

    always #5 clk = ~clk;

    calib_line_encoder #(.PRE_LEN(2), .MID_LEN(1)) u_dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid_a), .req_ready(rr_a),
        .req_first(req_first), .req_last(req_last), .req_spell(req_spell),
        .char_out(co_a), .char_valid(cv_a), .char_ready(char_ready),
        .line_done(ld_a), .bad_req(bad_a)
    );

    calib_line_encoder #(.PRE_LEN(0), .MID_LEN(0)) u_dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid_b), .req_ready(rr_b),
        .req_first(req_first), .req_last(req_last), .req_spell(req_spell),
        .char_out(co_b), .char_valid(cv_b), .char_ready(char_ready),
        .line_done(ld_b), .bad_req(bad_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    string words [0:9] = '{"", "one", "two", "three", "four", "five",
                           "six", "seven", "eight", "nine"};
    string digs  [0:9] = '{"0", "1", "2", "3", "4", "5", "6", "7", "8", "9"};

    // Scoreboard
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         sel_b = 1'b0;
    logic       mon_cv;
    logic [7:0] mon_co;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_char  = 8'h00;
    logic [7:0] e;

    assign mon_cv = sel_b ? cv_b : cv_a;
    assign mon_co = sel_b ? co_b : co_a;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", 32'(mon_cv), 32'd1);
                check("stall_char_held", 32'(mon_co), 32'(prev_char));
            end
            if (mon_cv && char_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_char: got %0h, none expected", mon_co);
                end else begin
                    e = exp_q.pop_front();
                    check("char", 32'(mon_co), 32'(e));
                end
                got_q.push_back(mon_co);
            end
            prev_stall = mon_cv && !char_ready;
            prev_char  = mon_co;
        end
    end

    task automatic push_str(input string s);
        for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
    endtask

    function automatic string digit_txt(input logic [3:0] d, input bit sp);
        logic [3:0] c;
        c = (d > 4'd9) ? 4'd0 : d;
        if (sp && c != 4'd0) return words[c];
        return digs[c];
    endfunction

    function automatic string build_line(input logic [3:0] f, input logic [3:0] l, input bit sp);
        return {"qq", digit_txt(f, sp), "q", digit_txt(l, sp), "\n"};
    endfunction

    function automatic bit match_at(input logic [7:0] s [$], input int i, input string w);
        if (w.len() == 0 || i + w.len() > s.size()) return 1'b0;
        for (int k = 0; k < w.len(); k++)
            if (s[i+k] != w[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Part-2 style extractor: first and last digit or digit word in the line
    function automatic logic [15:0] decode(input logic [7:0] s [$]);
        logic [7:0] fd, ld;
        bit found;
        int d;
        fd = 8'h00; ld = 8'h00; found = 1'b0;
        for (int i = 0; i < s.size(); i++) begin
            d = -1;
            if (s[i] >= 8'h30 && s[i] <= 8'h39) d = int'(s[i]) - 48;
            else for (int w = 1; w <= 9; w++) if (match_at(s, i, words[w])) d = w;
            if (d >= 0) begin
                if (!found) fd = 8'(48 + d);
                ld = 8'(48 + d);
                found = 1'b1;
            end
        end
        return {fd, ld};
    endfunction

    task automatic run_line(input bit use_b, input logic [3:0] f, input logic [3:0] l,
                            input bit sp, input string exp, input bit stall);
        int cyc;
        sel_b = use_b;
        got_q.delete();
        cyc = 0;
        while (!(use_b ? rr_b : rr_a) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("req_ready_idle", 32'(use_b ? rr_b : rr_a), 32'd1);
        req_first = f; req_last = l; req_spell = sp;
        if (use_b) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        push_str(exp);
        char_ready = 1'b1;
        @(posedge clk); #1;
        // Keep requesting with different operands: must be ignored mid-line
        req_first = 4'd6; req_last = 4'd15; req_spell = ~sp;
        check("latency_valid", 32'(use_b ? cv_b : cv_a), 32'd1);
        check("req_ready_busy", 32'(use_b ? rr_b : rr_a), 32'd0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 200) begin
            check("no_early_done", 32'(use_b ? ld_b : ld_a), 32'd0);
            char_ready = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        check("line_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        check("line_done", 32'(use_b ? ld_b : ld_a), 32'd1);
        check("req_ready_after", 32'(use_b ? rr_b : rr_a), 32'd1);
        check("valid_after", 32'(use_b ? cv_b : cv_a), 32'd0);
        if (!stall) check("beat_count", 32'(cyc), 32'(exp.len()));
        char_ready = 1'b1;
        @(posedge clk); #1;
        check("line_done_pulse", 32'(use_b ? ld_b : ld_a), 32'd0);
    endtask

    typedef struct {
        logic [3:0] f;
        logic [3:0] l;
        bit         sp;
        bit         use_b;
        bit         stall;
        string      exp;
        bit         exp_bad;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{4'd3,  4'd7, 1'b0, 1'b0, 1'b0, "qq3q7\n",         1'b0};
        vecs[1] = '{4'd3,  4'd7, 1'b1, 1'b0, 1'b0, "qqthreeqseven\n", 1'b0};
        vecs[2] = '{4'd3,  4'd7, 1'b1, 1'b0, 1'b1, "qqthreeqseven\n", 1'b0};
        vecs[3] = '{4'd0,  4'd9, 1'b1, 1'b1, 1'b0, "0nine\n",         1'b0};
        vecs[4] = '{4'd9,  4'd1, 1'b1, 1'b1, 1'b1, "nineone\n",       1'b0};
        vecs[5] = '{4'd12, 4'd5, 1'b0, 1'b0, 1'b0, "qq0q5\n",         1'b1};
        vecs[6] = '{4'd8,  4'd0, 1'b1, 1'b0, 1'b0, "qqeightq0\n",     1'b1};

        rst = 1'b0;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        req_first = 4'd0; req_last = 4'd0; req_spell = 1'b0;
        char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(rr_a), 32'd1);
        check("rst_char_valid", 32'(cv_a), 32'd0);
        check("rst_char_out", 32'(co_a), 32'h00);
        check("rst_line_done", 32'(ld_a), 32'd0);
        check("rst_bad_req", 32'(bad_a), 32'd0);
        check("rst_b_valid", 32'(cv_b), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) begin
            run_line(vecs[i].use_b, vecs[i].f, vecs[i].l, vecs[i].sp, vecs[i].exp, vecs[i].stall);
            check($sformatf("bad_req_vec%0d", i),
                  32'(vecs[i].use_b ? bad_b : bad_a), 32'(vecs[i].exp_bad));
        end
        check("bad_req_b_clean", 32'(bad_b), 32'd0);

        // Reset in the middle of the "three" word
        sel_b = 1'b0;
        exp_q.delete();
        push_str("qqth");
        req_first = 4'd3; req_last = 4'd7; req_spell = 1'b1;
        req_valid_a = 1'b1; char_ready = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        check("rst_mid_char", 32'(co_a), 32'h72);
        #2 rst = 1'b0;
        #1;
        check("abort_valid", 32'(cv_a), 32'd0);
        check("abort_line_done", 32'(ld_a), 32'd0);
        check("abort_ready", 32'(rr_a), 32'd1);
        check("abort_char_out", 32'(co_a), 32'h00);
        check("abort_bad_cleared", 32'(bad_a), 32'd0);
        check("abort_queue", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) begin
            @(posedge clk); #1;
            check("abort_no_done", 32'(ld_a), 32'd0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        run_line(1'b0, 4'd3, 4'd7, 1'b1, "qqthreeqseven\n", 1'b0);

        // Loopback of every digit pair through the extractor model
        for (int sp = 0; sp < 2; sp++) begin
            for (int f = 0; f < 10; f++) begin
                for (int l = 0; l < 10; l++) begin
                    run_line(1'b0, 4'(f), 4'(l), sp[0],
                             build_line(4'(f), 4'(l), sp[0]), 1'b0);
                    check($sformatf("decode_%0d%0d_s%0d", f, l, sp),
                          32'(decode(got_q)), 32'({8'(48 + f), 8'(48 + l)}));
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
